lfsr_agu_burst: RTL

Parametrised successor to the fixed 14-bit LFSR address generator. It provides configurable width and tap polynomial, parallel or serial seeding, and burst generation with a valid/ready handshake. It also has period-wrap detection and all-zero lock-up protection. It sits between the test/scramble controller and the memory address port, issuing one pseudo-random address per accepted handshake.

---
 rtl/lfsr_agu_burst.sv | 134 +++++++++++++
 1 files changed

// File: rtl/lfsr_agu_burst.sv
// Burst address generator driven by a Fibonacci LFSR with configurable width and taps.
// Supports parallel/serial seeding, valid/ready bursts, period-wrap detection and all-zero lock-up recovery.
module lfsr_agu_burst #(
  parameter int               WIDTH        = 14,
  parameter logic [WIDTH-1:0] TAPS         = 14'h3802,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1),
  parameter int               LEN_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             ser_en,
  input  logic             ser_in,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             addr_ready,
  output logic             addr_valid,
  output logic [WIDTH-1:0] addr,
  output logic             addr_last,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             lockup_err
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_fsm;
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_seed;
  logic [LEN_W-1:0] r_rem;
  logic             r_done;
  logic             r_wrap;
  logic             r_lock;

  state_t           w_fsm_n;
  logic [WIDTH-1:0] w_state_n;
  logic [WIDTH-1:0] w_seed_n;
  logic [LEN_W-1:0] w_rem_n;
  logic             w_done_n;
  logic             w_wrap_n;
  logic             w_lock_n;
  logic             w_fb;
  logic [WIDTH-1:0] w_adv;
  logic [WIDTH-1:0] w_ser;

  // bit0 is stage 1; new feedback enters at the bottom as the register shifts up
  assign w_fb  = ^(r_state & TAPS);
  assign w_adv = {r_state[WIDTH-2:0], w_fb};
  assign w_ser = {r_state[WIDTH-2:0], ser_in};

  always_comb begin
    w_fsm_n   = r_fsm;
    w_state_n = r_state;
    w_seed_n  = r_seed;
    w_rem_n   = r_rem;
    w_done_n  = 1'b0;
    w_wrap_n  = 1'b0;
    w_lock_n  = r_lock;
    case (r_fsm)
      S_IDLE: begin
        if (seed_load) begin
          if (seed_in != '0) begin
            w_state_n = seed_in;
            w_seed_n  = seed_in;
            w_lock_n  = 1'b0;
          end else begin
            w_state_n = SEED_DEFAULT;
            w_seed_n  = SEED_DEFAULT;
            w_lock_n  = 1'b1;
          end
        end else if (ser_en) begin
          w_state_n = w_ser;
          w_seed_n  = w_ser;
        end else if (start) begin
          if (r_state == '0) begin
            // a zero state would lock the LFSR forever: recover and refuse the burst
            w_state_n = SEED_DEFAULT;
            w_seed_n  = SEED_DEFAULT;
            w_lock_n  = 1'b1;
            w_done_n  = 1'b1;
          end else if (burst_len == '0) begin
            w_done_n  = 1'b1;
          end else begin
            w_rem_n   = burst_len;
            w_fsm_n   = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (addr_ready) begin
          w_state_n = w_adv;
          w_rem_n   = r_rem - LEN_W'(1);
          w_wrap_n  = (w_adv == r_seed);
          if (r_rem == LEN_W'(1)) begin
            w_fsm_n  = S_IDLE;
            w_done_n = 1'b1;
          end
        end
      end
      default: w_fsm_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm   <= S_IDLE;
      r_state <= SEED_DEFAULT;
      r_seed  <= SEED_DEFAULT;
      r_rem   <= '0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
      r_lock  <= 1'b0;
    end else begin
      r_fsm   <= w_fsm_n;
      r_state <= w_state_n;
      r_seed  <= w_seed_n;
      r_rem   <= w_rem_n;
      r_done  <= w_done_n;
      r_wrap  <= w_wrap_n;
      r_lock  <= w_lock_n;
    end
  end

  assign addr       = r_state;
  assign addr_valid = (r_fsm == S_RUN);
  assign busy       = (r_fsm == S_RUN);
  assign addr_last  = (r_fsm == S_RUN) && (r_rem == LEN_W'(1));
  assign done       = r_done;
  assign wrap       = r_wrap;
  assign lockup_err = r_lock;

endmodule
